// File: rtl/key_press_gen.sv
// key_press_gen: emulates an active-low push-button pin for on-board self-test
// of the key debounce/classifier. A one-cycle request starts a press sequence:
// optional press bounce, a low hold of short or long length, optional release
// bounce, then a released settle gap that ends with a one-cycle done pulse.
//
// Build option: define KEY_BOUNCE_EN to generate contact bounce around both
// edges. Without it the bounce states do not exist and the pin has clean edges.
module key_press_gen #(
  parameter int unsigned CLK_FREQ   = 27_000_000,
  parameter int unsigned SHORT_MS   = 200,
  parameter int unsigned LONG_MS    = 1500,
  parameter int unsigned GAP_MS     = 50,
  parameter int unsigned BOUNCE_N   = 3,
  parameter int unsigned BOUNCE_CYC = 2700
) (
  input  logic clk,
  input  logic rst,
  input  logic req_short,
  input  logic req_long,
  output logic key_out,
  output logic busy,
  output logic done
);

  // Phase lengths in clock cycles. All lengths are expected to be at least 1.
  localparam logic [31:0] CNT_SHORT = 32'((CLK_FREQ / 1000) * SHORT_MS);
  localparam logic [31:0] CNT_LONG  = 32'((CLK_FREQ / 1000) * LONG_MS);
  localparam logic [31:0] CNT_GAP   = 32'((CLK_FREQ / 1000) * GAP_MS);

`ifdef KEY_BOUNCE_EN
  // Each edge produces 2*BOUNCE_N segments of BOUNCE_CYC cycles.
  localparam int unsigned NSEG     = 2 * BOUNCE_N;
  localparam int unsigned SEG_W    = (NSEG < 2) ? 1 : $clog2(NSEG);
  localparam logic [31:0] BNC_LAST = 32'(BOUNCE_CYC - 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'((NSEG == 0) ? 0 : NSEG - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    GAP
`ifdef KEY_BOUNCE_EN
    ,
    PRESS_BNC,
    REL_BNC
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;          // cycle count within the current phase/segment
  logic [31:0] hold_len_q, hold_len_d; // hold length latched at acceptance
  logic        key_q, key_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef KEY_BOUNCE_EN
  logic [SEG_W-1:0] seg_q, seg_d;     // bounce segment index; bit 0 picks the level
`endif

  // Next-state and next-output decode; outputs are computed from the next state
  // so they are registered and line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    hold_len_d = hold_len_q;
`ifdef KEY_BOUNCE_EN
    seg_d      = seg_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        // Long wins when both requests arrive together.
        if (req_short || req_long) begin
          hold_len_d = req_long ? CNT_LONG : CNT_SHORT;
`ifdef KEY_BOUNCE_EN
          state_d = (NSEG != 0) ? PRESS_BNC : HOLD;
          seg_d   = '0;
`else
          state_d = HOLD;
`endif
        end
      end

`ifdef KEY_BOUNCE_EN
      PRESS_BNC: begin
        if (cnt_q == BNC_LAST) begin
          cnt_d = 32'd0;
          if (seg_q == SEG_LAST) begin
            seg_d   = '0;
            state_d = HOLD;
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end
      end
`endif

      HOLD: begin
        if (cnt_q == hold_len_q - 32'd1) begin
          cnt_d = 32'd0;
`ifdef KEY_BOUNCE_EN
          seg_d   = '0;
          state_d = (NSEG != 0) ? REL_BNC : GAP;
`else
          state_d = GAP;
`endif
        end
      end

`ifdef KEY_BOUNCE_EN
      REL_BNC: begin
        if (cnt_q == BNC_LAST) begin
          cnt_d = 32'd0;
          if (seg_q == SEG_LAST) begin
            seg_d   = '0;
            state_d = GAP;
          end else begin
            seg_d = seg_q + 1'b1;
          end
        end
      end
`endif

      GAP: begin
        if (cnt_q == CNT_GAP - 32'd1) begin
          cnt_d   = 32'd0;
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = 32'd0;
        state_d = IDLE;
      end
    endcase

    // Pin level for the cycle the next state occupies.
    case (state_d)
      HOLD:      key_d = 1'b0;
`ifdef KEY_BOUNCE_EN
      PRESS_BNC: key_d = seg_d[0];   // low, high, low, ...
      REL_BNC:   key_d = ~seg_d[0];  // high, low, high, ...
`endif
      default:   key_d = 1'b1;       // IDLE and GAP: released
    endcase

    busy_d = (state_d != IDLE);
    // done marks the final GAP cycle.
    done_d = (state_d == GAP) && (cnt_d == CNT_GAP - 32'd1);
  end

  // State, counters and registered outputs; reset acts immediately, even mid-press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      hold_len_q <= 32'd0;
      key_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef KEY_BOUNCE_EN
      seg_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hold_len_q <= hold_len_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef KEY_BOUNCE_EN
      seg_q      <= seg_d;
`endif
    end
  end

  assign key_out = key_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Bench for key_press_gen with small timing parameters. A queue-based model
// expands each accepted request into its per-cycle {key_out,busy,done} list and
// is compared every cycle; literal checks pin the model at key cycles.
module tb_key_press_gen;

  localparam int unsigned CLK_FREQ   = 1000;
  localparam int unsigned SHORT_MS   = 5;
  localparam int unsigned LONG_MS    = 12;
  localparam int unsigned GAP_MS     = 3;
  localparam int unsigned BOUNCE_N   = 2;
  localparam int unsigned BOUNCE_CYC = 2;

  localparam int M_SHORT = (CLK_FREQ / 1000) * SHORT_MS;
  localparam int M_LONG  = (CLK_FREQ / 1000) * LONG_MS;
  localparam int M_GAP   = (CLK_FREQ / 1000) * GAP_MS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_short = 1'b0;
  logic req_long  = 1'b0;
  logic key_out, busy, done;

  int checks = 0;
  int passes = 0;
  int cur = 0;   // cycle number relative to the latest request (cycle 0)

  key_press_gen #(
    .CLK_FREQ(CLK_FREQ), .SHORT_MS(SHORT_MS), .LONG_MS(LONG_MS),
    .GAP_MS(GAP_MS), .BOUNCE_N(BOUNCE_N), .BOUNCE_CYC(BOUNCE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req_short(req_short), .req_long(req_long),
    .key_out(key_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got {key,busy,done}=%b want %b at %0t", name, act, exp, $time);
  endtask

  // Model: pending per-cycle outputs of the sequence in progress.
  logic [2:0] q[$];

  task automatic push_seq(input int hold);
`ifdef KEY_BOUNCE_EN
    for (int s = 0; s < 2 * BOUNCE_N; s++)
      for (int c = 0; c < BOUNCE_CYC; c++) q.push_back({(s % 2 == 1), 1'b1, 1'b0});
`endif
    for (int h = 0; h < hold; h++) q.push_back(3'b010);
`ifdef KEY_BOUNCE_EN
    for (int s = 0; s < 2 * BOUNCE_N; s++)
      for (int c = 0; c < BOUNCE_CYC; c++) q.push_back({(s % 2 == 0), 1'b1, 1'b0});
`endif
    for (int g = 0; g < M_GAP; g++) q.push_back({1'b1, 1'b1, (g == M_GAP - 1)});
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      automatic bit idle = (q.size() == 0);
      if (!idle) void'(q.pop_front());
      if (idle && (req_short || req_long)) push_seq(req_long ? M_LONG : M_SHORT);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) chk("model", {key_out, busy, done}, (q.size() != 0) ? q[0] : 3'b100);
  end

  task automatic step();
    @(negedge clk);
    cur++;
  endtask

  task automatic at(input int n, input logic [2:0] exp, input string name);
    while (cur < n) step();
    chk(name, {key_out, busy, done}, exp);
  endtask

  task automatic wait_done(input int maxc, input string name);
    bit seen = 0;
    for (int k = 0; k < maxc; k++) begin
      if (done) begin seen = 1; break; end
      step();
    end
    checks++;
    if (seen) passes++;
    else $display("FAIL %s: got no done within %0d cycles, want done", name, maxc);
  endtask

  // Pulse a request during the current cycle; afterwards we are in cycle 1.
  task automatic request(input logic s, input logic l);
    req_short = s; req_long = l;
    cur = 0;
    step();
    req_short = 1'b0; req_long = 1'b0;
  endtask

  initial begin
    // Requests while in reset must be ignored.
    repeat (2) @(negedge clk);
    req_short = 1'b1;
    @(negedge clk);
    req_short = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      chk("idle", {key_out, busy, done}, 3'b100);
      @(negedge clk);
    end

    // Short press.
    request(1'b1, 1'b0);
`ifdef KEY_BOUNCE_EN
    at(1, 3'b010, "s_bnc1");  at(3, 3'b110, "s_bnc3");  at(5, 3'b010, "s_bnc5");
    at(8, 3'b110, "s_bnc8");  at(9, 3'b010, "s_hold9"); at(13, 3'b010, "s_hold13");
    at(14, 3'b110, "s_rel14"); at(16, 3'b010, "s_rel16"); at(21, 3'b010, "s_rel21");
    at(22, 3'b110, "s_gap22"); at(24, 3'b111, "s_done24"); at(25, 3'b100, "s_idle25");
`else
    at(1, 3'b010, "s_low1");  at(5, 3'b010, "s_low5");  at(6, 3'b110, "s_gap6");
    at(7, 3'b110, "s_gap7");  at(8, 3'b111, "s_done8"); at(9, 3'b100, "s_idle9");
`endif
    repeat (3) step();

    // Both requests together select long; a short request mid-press is ignored.
    request(1'b1, 1'b1);
    while (cur < 4) step();
    request(1'b1, 1'b0);
    cur = 5;
`ifdef KEY_BOUNCE_EN
    at(20, 3'b010, "l_hold20"); at(21, 3'b110, "l_rel21");
    at(31, 3'b111, "l_done31"); at(32, 3'b100, "l_idle32"); at(36, 3'b100, "l_noretrig");
`else
    at(12, 3'b010, "l_low12");  at(13, 3'b110, "l_gap13");
    at(15, 3'b111, "l_done15"); at(16, 3'b100, "l_idle16"); at(20, 3'b100, "l_noretrig");
`endif

    // Back-to-back: long request in the first idle cycle after done.
    request(1'b1, 1'b0);
    wait_done(100, "b2b_first_done");
    step();
    chk("b2b_idle", {key_out, busy, done}, 3'b100);
    request(1'b0, 1'b1);
    chk("b2b_start", {key_out, busy, done}, 3'b010);
    wait_done(100, "b2b_second_done");
    repeat (3) step();

    // Reset in the middle of a long hold.
    request(1'b0, 1'b1);
    at(10, 3'b010, "r_hold10");
    #2 rst = 1'b1;
    #1 chk("r_async", {key_out, busy, done}, 3'b100);
    step();
    step();
    rst = 1'b0;
    step();
    chk("r_after", {key_out, busy, done}, 3'b100);
    request(1'b1, 1'b0);
    chk("r_short_start", {key_out, busy, done}, 3'b010);
    wait_done(100, "r_short_done");
    step();
    chk("r_short_end", {key_out, busy, done}, 3'b100);
    repeat (3) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
